// File: rtl/bcd_to_bin_pkg.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_pkg
//   Shared definitions for the BCD-to-binary converter:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - default DIGITS / BIN_W
//   - digit-correction constants used by the reverse double-dabble step
// ---------------------------------------------------------------------------
package bcd_to_bin_pkg;

    localparam int DIGITS_DEF = 4;
    localparam int BIN_W_DEF  = 14;

    // A shifted BCD digit at or above 8 came from an odd upper digit that
    // contributed 10 (not 16) to the lower one; taking 3 away restores it.
    localparam logic [3:0] DIG_THRESH = 4'd8;
    localparam logic [3:0] DIG_ADJ    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_sub3.sv
// ---------------------------------------------------------------------------
// bcd_digit_sub3
//   Per-digit correction for the reverse double-dabble shift:
//   q = (d >= 8) ? d - 3 : d
// Ports:
//   d  in  4  shifted BCD digit
//   q  out 4  corrected digit
// ---------------------------------------------------------------------------
import bcd_to_bin_pkg::*;

module bcd_digit_sub3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= DIG_THRESH) ? (d - DIG_ADJ) : d;

endmodule

// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
//   Multi-cycle packed-BCD to binary converter (reverse double-dabble).
//   A legal request takes BIN_W shift cycles; a request holding any digit
//   above 9 is flagged on err and completes immediately with bin = 0.
// Ports:
//   clk      in   1          clock, rising edge
//   reset_n  in   1          asynchronous active-low reset
//   start    in   1          conversion request, sampled only in IDLE
//   bcd      in   4*DIGITS   packed BCD, digit 0 in [3:0]
//   bin      out  BIN_W      registered result
//   valid    out  1          one-cycle pulse: new bin/err available
//   busy     out  1          high in SHIFT and DONE (requests ignored)
//   err      out  1          last accepted bcd had a digit > 9
// ---------------------------------------------------------------------------
import bcd_to_bin_pkg::*;

module bcd_to_bin #(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  valid,
    output logic                  busy,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    // Must reach BIN_W itself without wrapping.
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;

    logic [DIGITS-1:0]  dig_bad;
    logic               bad;
    logic               last_iter;

    logic [BCD_W-1:0]   bcd_sh;
    logic [BCD_W-1:0]   bcd_fix;
    logic [BIN_W-1:0]   bin_sh;

    // -----------------------------------------------------------------
    // Input legality and per-digit correction of the shifted BCD register
    // -----------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            assign dig_bad[g] = (bcd[4*g +: 4] > 4'd9);

            bcd_digit_sub3 u_sub3 (
                .d (bcd_sh[4*g +: 4]),
                .q (bcd_fix[4*g +: 4])
            );
        end
    endgenerate

    assign bad = |dig_bad;

    // {bcd_reg, bin_reg} >> 1: bcd LSB falls into the binary MSB.
    assign bcd_sh = {1'b0, bcd_reg[BCD_W-1:1]};
    assign bin_sh = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // -----------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = bad ? DONE : SHIFT;
            SHIFT:   if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------
    // FSM: outputs (decoded straight from the state register)
    // -----------------------------------------------------------------
    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE: begin
                valid = 1'b1;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin     <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad) begin
                            bin <= '0;
                            err <= 1'b1;
                        end else begin
                            bcd_reg <= bcd;
                            bin_reg <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_fix;
                    bin_reg <= bin_sh;
                    cnt     <= cnt + CNT_W'(1);
                    // Publish the post-shift value directly so bin is valid
                    // in the DONE cycle.
                    if (last_iter) begin
                        bin <= bin_sh;
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin
//   Self-checking bench: default 4-digit instance plus a 2-digit instance.
//   Expected results come from a decimal reference model (digit * 10^i).
// ---------------------------------------------------------------------------
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        start = 1'b0;
    logic [15:0] bcd = '0;
    logic [13:0] bin;
    logic        valid, busy, err;

    logic        start2 = 1'b0;
    logic [7:0]  bcd2 = '0;
    logic [6:0]  bin2;
    logic        valid2, busy2, err2;

    int n_chk = 0;
    int n_err = 0;
    int vpulses = 0;

    always #5 clk = ~clk;

    bcd_to_bin dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bcd     (bcd),
        .bin     (bin),
        .valid   (valid),
        .busy    (busy),
        .err     (err)
    );

    bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start2),
        .bcd     (bcd2),
        .bin     (bin2),
        .valid   (valid2),
        .busy    (busy2),
        .err     (err2)
    );

    always @(negedge clk) if (valid) vpulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the digits, or (0, bad) if any digit > 9.
    task automatic ref_conv(input logic [15:0] b, input int nd, output int val, output bit bad);
        val = 0;
        bad = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            int d;
            d = int'((b >> (4 * i)) & 16'hF);
            if (d > 9) bad = 1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endtask

    // One conversion on the 4-digit instance. poke_at: SHIFT cycle at which
    // a competing start is raised; start_in_done: raise start during DONE.
    task automatic run(input logic [15:0] v, input int poke_at, input bit start_in_done);
        int exp_v, n, p0;
        bit exp_bad;
        ref_conv(v, 4, exp_v, exp_bad);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        p0 = vpulses;
        start = 1'b1;
        bcd   = v;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_accept", 32'(busy), 1);
        n = 0;
        while (!valid && n < 40) begin
            bcd = 16'($urandom);
            if (n == poke_at) begin
                start = 1'b1;
                bcd   = v ^ 16'h0111;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk("latency", n, exp_bad ? 0 : 14);
        chk("bin", 32'(bin), exp_v);
        chk("err", 32'(err), 32'(exp_bad));
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("valid_drop", 32'(valid), 0);
        chk("busy_drop", 32'(busy), 0);
        chk("one_pulse", vpulses - p0, 1);
        chk("bin_hold", 32'(bin), exp_v);
        if (start_in_done) begin
            @(posedge clk); #1;
            chk("done_start_ignored", 32'(busy), 0);
        end
    endtask

    // Reset 7 SHIFT cycles into a conversion, then convert 0500.
    task automatic rst_mid(input logic [15:0] v);
        int p0;
        @(negedge clk);
        p0 = vpulses;
        start = 1'b1;
        bcd   = v;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_bin", 32'(bin), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_err", 32'(err), 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_no_pulse", vpulses - p0, 0);
        run(16'h0500, -1, 0);
    endtask

    task automatic run2(input logic [7:0] v);
        int exp_v, n;
        bit exp_bad;
        ref_conv({8'h00, v}, 2, exp_v, exp_bad);
        @(negedge clk);
        start2 = 1'b1;
        bcd2   = v;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!valid2 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("d2_latency", n, exp_bad ? 0 : 7);
        chk("d2_bin", 32'(bin2), exp_v);
        chk("d2_err", 32'(err2), 32'(exp_bad));
        @(posedge clk); #1;
        chk("d2_busy_drop", 32'(busy2), 0);
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  v2;
        int k;

        #12;
        chk("reset_bin", 32'(bin), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        @(negedge clk);
        reset_n = 1'b1;

        run(16'h9999, -1, 0);
        run(16'h0000, -1, 0);
        run(16'h1234, -1, 0);
        run(16'h0010, -1, 0);
        run(16'h12A4, -1, 0);
        run(16'h0042, -1, 0);
        run(16'h5678, 5, 0);
        run(16'h0321, -1, 1);
        run(16'h1234, -1, 0);
        rst_mid(16'h8765);

        for (int i = 0; i < 30; i++) begin
            for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) begin
                k = int'($urandom_range(0, 3));
                v[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            run(v, (i % 3 == 0) ? int'($urandom_range(0, 12)) : -1, i[0]);
        end

        run2(8'h99);
        run2(8'h00);
        run2(8'h9A);
        for (int i = 0; i < 10; i++) begin
            v2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run2(v2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD digits at the input; legal values 2..4.
REQ-002 Parameter BIN_W, default 14: binary result width; SHALL be >= ceil(log2(10^DIGITS)), giving 14 for DIGITS=4 and 7 for DIGITS=2.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: conversion request; sampled only in IDLE.
REQ-006 Port bcd, input, 4*DIGITS: packed BCD, digit 0 in bits [3:0].
REQ-007 Port bin, output, BIN_W: converted binary value, registered.
REQ-008 Port valid, output, 1: one-cycle pulse marking a new result on bin/err.
REQ-009 Port busy, output, 1: high while a request is held off (SHIFT or DONE).
REQ-010 Port err, output, 1: set when the last accepted bcd held a digit > 9.

Function
REQ-011 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 and all digits <= 9, the edge SHALL load bcd into the BCD shift register, clear the binary register, clear the iteration counter and enter SHIFT.
REQ-013 In IDLE with start=1 and any digit > 9, the edge SHALL set bin=0 and err=1 and enter DONE directly, with no SHIFT cycles.
REQ-014 Each SHIFT edge SHALL shift {bcd_reg, bin_reg} right by 1, so bcd_reg LSB enters bin_reg MSB, and SHALL then subtract 3 from every shifted digit whose value is >= 8, all digits in parallel within the same cycle.
REQ-015 SHIFT SHALL perform exactly BIN_W iterations and then enter DONE; the counter SHALL be wide enough to hold BIN_W without wrap-around.
REQ-016 On entering DONE from SHIFT, bin SHALL take the final bin_reg and err SHALL be 0.
REQ-017 valid SHALL be 1 exactly during the DONE cycle; DONE SHALL return to IDLE on the next edge.
REQ-018 Latency: for a legal input accepted at edge E0, valid SHALL be high in the cycle after edge E(BIN_W), which is E14 for the defaults.
REQ-019 Latency: for an illegal input accepted at edge E0, valid SHALL be high in the cycle after E0.
REQ-020 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; start while busy SHALL be ignored, with no queueing.
REQ-021 bin and err SHALL hold their last values in IDLE until the next accepted start.
REQ-022 A start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; acceptance requires start=1 while in IDLE.
REQ-023 bcd SHALL be sampled only at the accepting edge; changes to bcd during SHIFT SHALL not affect the result.

Reset
REQ-024 reset_n=0 SHALL immediately force state=IDLE, bin=0, valid=0, busy=0, err=0, and clear the counter and shift registers, independent of clk.
REQ-025 Reset asserted mid-conversion SHALL abandon the conversion with no valid pulse; the first start after release SHALL be accepted normally.

Structure
REQ-026 A shared package/include file SHALL hold the state encoding (IDLE, SHIFT, DONE), the default DIGITS/BIN_W constants and the digit-correction constants (threshold 8, adjust 3).
REQ-027 The digit correction (4-bit in, 4-bit out, value >= 8 minus 3) SHALL be one sub-module, bcd_digit_sub3, instantiated once per digit via generate.

Verification
REQ-028 Scenario: bcd=16'h9999, start one cycle -> busy high, valid high in the cycle after edge 14, bin=14'd9999, err=0.
REQ-029 Scenario: bcd=16'h0000 -> bin=0, err=0; bcd=16'h1234 -> bin=1234; bcd=16'h0010 -> bin=10.
REQ-030 Scenario: bcd=16'h12A4 -> valid in the cycle after the accepting edge, bin=0, err=1; a following legal 16'h0042 -> bin=42, err=0.
REQ-031 Scenario: start again at SHIFT cycle 5 with a different bcd -> ignored, exactly one valid pulse, result from the first operand.
REQ-032 Scenario: reset_n low at SHIFT cycle 7 -> all outputs 0 at once, no valid pulse; a new start of 16'h0500 after release -> bin=500.
REQ-033 Scenario: DIGITS=2, BIN_W=7, bcd=8'h99 -> bin=7'd99 after 7 shifts.
